// File: rtl/medidor_distancia_dual.sv
// Dual HC-SR04 ranging front end: alternately triggers left/right sensors and times each echo.
// Optional MEDIDOR_MEDIA_EN: publish the mean of the latest two results of each side.
module medidor_distancia_dual #(
  parameter int unsigned TICKS_PER_CM  = 2941,
  parameter int unsigned TRIG_TICKS    = 500,
  parameter int unsigned TIMEOUT_TICKS = 1500000,
  parameter int unsigned GAP_TICKS     = 3000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ligar,
  input  logic        echo_esq,
  input  logic        echo_dir,
  output logic        trigger_esq,
  output logic        trigger_dir,
  output logic [11:0] medida_esq,
  output logic [11:0] medida_dir,
  output logic        timeout_esq,
  output logic        timeout_dir,
  output logic        pronto
);

  localparam int unsigned MaxA     = (TIMEOUT_TICKS > GAP_TICKS) ? TIMEOUT_TICKS : GAP_TICKS;
  localparam int unsigned MaxTicks = (MaxA > TRIG_TICKS) ? MaxA : TRIG_TICKS;
  localparam int unsigned CntW     = $clog2(MaxTicks + 1);
  localparam int unsigned SubW     = (TICKS_PER_CM > 1) ? $clog2(TICKS_PER_CM) : 1;

  localparam logic [CntW-1:0] TrigLast    = CntW'(TRIG_TICKS - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_TICKS - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'(GAP_TICKS - 1);
  localparam logic [SubW-1:0] SubLast     = SubW'(TICKS_PER_CM - 1);

  typedef enum logic [2:0] {
    StInicial, StTrig, StEspera, StMede, StArmazena, StFalha, StIntervalo
  } estado_e;

  estado_e         estado_q, estado_d;
  logic            lado_q, lado_d;  // 0 = esq, 1 = dir
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SubW-1:0] sub_q, sub_d, sub_inc;
  logic [11:0]     cm_q, cm_d, cm_inc;
  logic            esq_meta_q, esq_sync_q, dir_meta_q, dir_sync_q;
  logic [11:0]     medida_esq_q, medida_dir_q;
  logic            timeout_esq_q, timeout_dir_q, pronto_q;
  logic            echo_ativo, grava;
  logic [11:0]     novo, publicado;

  assign echo_ativo = lado_q ? dir_sync_q : esq_sync_q;

  // One echo tick: sub-count wraps into a saturating cm count.
  always_comb begin
    sub_inc = sub_q + SubW'(1);
    cm_inc  = cm_q;
    if (sub_q == SubLast) begin
      sub_inc = '0;
      if (cm_q != 12'hFFF) cm_inc = cm_q + 12'd1;
    end
  end

  always_comb begin
    estado_d = estado_q;
    lado_d   = lado_q;
    cnt_d    = cnt_q;
    sub_d    = sub_q;
    cm_d     = cm_q;
    case (estado_q)
      StInicial: begin
        if (ligar) begin
          estado_d = StTrig;
          cnt_d    = '0;
        end
      end
      StTrig: begin
        if (cnt_q == TrigLast) begin
          estado_d = StEspera;
          cnt_d    = '0;
          sub_d    = '0;
          cm_d     = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StEspera: begin
        // The rise cycle is itself the first timed tick of the echo.
        if (echo_ativo) begin
          estado_d = StMede;
          cnt_d    = CntW'(1);
          sub_d    = sub_inc;
          cm_d     = cm_inc;
        end else if (cnt_q == TimeoutLast) begin
          estado_d = StFalha;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StMede: begin
        if (!echo_ativo) begin
          estado_d = StArmazena;
        end else if (cnt_q == TimeoutLast) begin
          estado_d = StFalha;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          sub_d = sub_inc;
          cm_d  = cm_inc;
        end
      end
      StArmazena, StFalha: begin
        estado_d = StIntervalo;
        cnt_d    = '0;
      end
      StIntervalo: begin
        if (cnt_q == GapLast) begin
          lado_d   = ~lado_q;
          cnt_d    = '0;
          estado_d = ligar ? StTrig : StInicial;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: estado_d = StInicial;
    endcase
  end

  assign grava = (estado_q == StArmazena) || (estado_q == StFalha);
  assign novo  = (estado_q == StFalha) ? 12'hFFF : cm_q;

`ifdef MEDIDOR_MEDIA_EN
  logic [11:0] ant_esq_q, ant_dir_q, anterior;
  logic [12:0] soma;

  assign anterior  = lado_q ? ant_dir_q : ant_esq_q;
  assign soma      = {1'b0, novo} + {1'b0, anterior};
  assign publicado = 12'(soma >> 1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      ant_esq_q <= 12'hFFF;
      ant_dir_q <= 12'hFFF;
    end else if (grava) begin
      if (lado_q) ant_dir_q <= novo;
      else        ant_esq_q <= novo;
    end
  end
`else
  assign publicado = novo;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q      <= StInicial;
      lado_q        <= 1'b0;
      cnt_q         <= '0;
      sub_q         <= '0;
      cm_q          <= '0;
      esq_meta_q    <= 1'b0;
      esq_sync_q    <= 1'b0;
      dir_meta_q    <= 1'b0;
      dir_sync_q    <= 1'b0;
      medida_esq_q  <= 12'hFFF;
      medida_dir_q  <= 12'hFFF;
      timeout_esq_q <= 1'b0;
      timeout_dir_q <= 1'b0;
      pronto_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      lado_q     <= lado_d;
      cnt_q      <= cnt_d;
      sub_q      <= sub_d;
      cm_q       <= cm_d;
      esq_meta_q <= echo_esq;
      esq_sync_q <= esq_meta_q;
      dir_meta_q <= echo_dir;
      dir_sync_q <= dir_meta_q;
      pronto_q   <= grava && lado_q;
      if (grava && !lado_q) begin
        medida_esq_q  <= publicado;
        timeout_esq_q <= (estado_q == StFalha);
      end
      if (grava && lado_q) begin
        medida_dir_q  <= publicado;
        timeout_dir_q <= (estado_q == StFalha);
      end
    end
  end

  assign trigger_esq = (estado_q == StTrig) && !lado_q;
  assign trigger_dir = (estado_q == StTrig) && lado_q;
  assign medida_esq  = medida_esq_q;
  assign medida_dir  = medida_dir_q;
  assign timeout_esq = timeout_esq_q;
  assign timeout_dir = timeout_dir_q;
  assign pronto      = pronto_q;

endmodule
